// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter that loads one requester's word per cycle into a shared holding register
// and presents it downstream with its source index over a valid/ready handshake.
module rr_reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_W-1:0]       out_src,
    input  logic                   out_ready
);

    logic [SRC_W-1:0] rr_ptr;
    logic             load_en;
    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             transfer;
    logic [WIDTH-1:0] words [N_REQ];

    // The register can take a new word when empty or when its current word leaves this edge.
    assign load_en  = !out_valid || out_ready;
    assign transfer = load_en && grant_found && !sync_rst;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            words[k] = req_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = SRC_W'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
                grant_data  = words[cand];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant_idx;
            rr_ptr    <= (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
        end else if (out_ready) begin
            // Drained with nothing to reload; data and source keep their last value.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Self-checking bench for rr_reg_write_arbiter: directed vector table, corner sequences,
// random traffic against a behavioural model, and a single-requester scoreboard run.
module tb_rr_reg_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Four-requester, 8-bit instance
    logic        sync_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    // Single-requester, 16-bit instance
    logic        rst1;
    logic [0:0]  v1;
    logic [15:0] d1;
    logic [0:0]  rdy1;
    logic        ov1;
    logic [15:0] od1;
    logic [0:0]  os1;
    logic        ro1;

    rr_reg_write_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .sync_rst(sync_rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    rr_reg_write_arbiter #(.N_REQ(1), .WIDTH(16)) dut1 (
        .clk(clk), .sync_rst(rst1), .req_valid(v1), .req_data(d1),
        .req_ready(rdy1), .out_valid(ov1), .out_data(od1),
        .out_src(os1), .out_ready(ro1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model of the four-requester instance
    int m_valid, m_data, m_src, m_ptr;

    function automatic int m_winner(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_ready(input logic r, input logic [3:0] v, input logic ro);
        int w;
        w = m_winner(v);
        if (r || !(m_valid == 0 || ro) || w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    task automatic m_update(input logic r, input logic [3:0] v, input logic [31:0] d, input logic ro);
        int w;
        w = m_winner(v);
        if (r) begin
            m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        end else if ((m_valid == 0 || ro) && w >= 0) begin
            m_valid = 1;
            m_data  = int'((d >> (8 * w)) & 32'hff);
            m_src   = w;
            m_ptr   = (w + 1) % 4;
        end else if (m_valid != 0 && ro) begin
            m_valid = 0;
        end
    endtask

    // One cycle, entered and left at negedge; checks req_ready before the edge and outputs after.
    task automatic step(input logic r, input logic [3:0] v, input logic [31:0] d, input logic ro,
                        input string tag);
        logic [3:0] exp_rdy;
        sync_rst = r; req_valid = v; req_data = d; out_ready = ro;
        #1;
        exp_rdy = m_ready(r, v, ro);
        check({tag, " req_ready"}, 32'(req_ready), 32'(exp_rdy));
        m_update(r, v, d, ro);
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, " out_data"},  32'(out_data),  32'(m_data));
        check({tag, " out_src"},   32'(out_src),   32'(m_src));
        @(negedge clk);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       ro;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_src;
    } vec_t;

    vec_t tbl[13];

    localparam logic [31:0] DATA_A = 32'hA3A2A1A0;

    logic [15:0] sb_q[$];
    int          accepted;
    int          delivered;

    initial begin
        // Reset, full-load rotation, then backpressure while holding src 1.
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
        for (int i = 7; i < 12; i++) begin
            tbl[i] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
        end
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};

        sync_rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        rst1 = 1'b1; v1 = '0; d1 = '0; ro1 = 1'b0;
        m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            sync_rst = tbl[i].rst; req_valid = tbl[i].v; req_data = DATA_A; out_ready = tbl[i].ro;
            #1;
            check($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
            m_update(tbl[i].rst, tbl[i].v, DATA_A, tbl[i].ro);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(tbl[i].exp_data));
            check($sformatf("vec%0d out_src", i),   32'(out_src),   32'(tbl[i].exp_src));
            @(negedge clk);
        end

        // Reset mid-transfer, then first grant after reset must go to requester 0.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0110, $urandom, 1'b1, "rst pre");
        step(1'b1, 4'b1111, $urandom, 1'b1, "rst mid");
        check("rst out_data zero", 32'(out_data), 32'h0);
        step(1'b0, 4'b1111, DATA_A, 1'b1, "rst after");
        check("rst first grant", 32'(out_src), 32'd0);

        // Sparse/wrap: lone req 2 moves the pointer to 3, then 3 beats 0, then 0.
        step(1'b1, 4'b0000, DATA_A, 1'b1, "wrap rst");
        step(1'b0, 4'b0100, DATA_A, 1'b1, "wrap r2");
        step(1'b0, 4'b1001, DATA_A, 1'b1, "wrap a");
        check("wrap first src", 32'(out_src), 32'd3);
        step(1'b0, 4'b1001, DATA_A, 1'b1, "wrap b");
        check("wrap second src", 32'(out_src), 32'd0);

        // Drain to empty: one word from req 1, valid for exactly one cycle, pointer left at 2.
        step(1'b1, 4'b0000, DATA_A, 1'b1, "drain rst");
        step(1'b0, 4'b0010, DATA_A, 1'b1, "drain load");
        check("drain valid high", 32'(out_valid), 32'd1);
        step(1'b0, 4'b0000, DATA_A, 1'b1, "drain empty");
        check("drain valid low", 32'(out_valid), 32'd0);
        check("drain data held", 32'(out_data), 32'hA1);
        step(1'b0, 4'b0000, DATA_A, 1'b1, "drain idle");
        step(1'b0, 4'b1111, DATA_A, 1'b1, "drain ptr");
        check("drain ptr is 2", 32'(out_src), 32'd2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), 4'($urandom), $urandom,
                 ($urandom_range(0, 3) != 0), "rand");
        end

        // Single requester, 16-bit: continuous valid, random backpressure, in-order scoreboard.
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check("n1 reset valid", 32'(ov1), 32'd0);
        check("n1 reset data", 32'(od1), 32'd0);
        accepted = 0; delivered = 0;
        for (int i = 0; i < 403; i++) begin
            v1  = (i < 400) ? 1'b1 : 1'b0;
            ro1 = (i < 400) ? 1'($urandom) : 1'b1;
            d1  = 16'($urandom);
            #1;
            check("n1 req_ready", 32'(rdy1), 32'(v1[0] && (!ov1 || ro1)));
            if (ov1 && ro1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL n1 spurious word: got %0h expected none", od1);
                end else begin
                    check("n1 out_data", 32'(od1), 32'(sb_q.pop_front()));
                    check("n1 out_src", 32'(os1), 32'd0);
                    delivered++;
                end
            end
            if (v1[0] && rdy1[0]) begin
                sb_q.push_back(d1);
                accepted++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("n1 all delivered", 32'(delivered), 32'(accepted));
        check("n1 queue empty", 32'(sb_q.size()), 32'd0);
        check("n1 final valid", 32'(ov1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
